// File: rtl/fifo_stream_drain.sv
// Drains the team FIFO into a registered valid/ready stream.
// A 2-slot skid buffer sustains one word per cycle and absorbs sink backpressure.

package definitions;
  localparam int WIDTH = 8;
endpackage

module fifo_stream_drain #(
  parameter int WIDTH = definitions::WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_out,
  input  logic             fifo_push,
  output logic             fifo_pop,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CNT_W-1:0] words_out,
  output logic [1:0]       dbg_state
);

  // Stream handshake: a word moves on every rising edge where m_valid && m_ready;
  // m_valid and m_data are registered and hold steady until that edge.

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] slot0_q, slot1_q, slot0_d, slot1_d;
  logic [CNT_W-1:0] words_q;
  logic             drn;

  // Case equality makes any X on the controls resolve to "no pop".
  assign fifo_pop = (reset === 1'b0) && (enable === 1'b1) && (fifo_empty === 1'b0) &&
                    (fifo_push === 1'b0) && ((state_q == EMPTY) || (state_q == ONE));

  assign m_valid   = (state_q != EMPTY);
  assign m_data    = slot0_q;
  assign drn       = m_valid && m_ready;
  assign words_out = words_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      slot0_q <= '0;
      slot1_q <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      if (drn) words_q <= words_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    case (state_q)
      EMPTY: begin
        if (fifo_pop) begin
          state_d = ONE;
          slot0_d = fifo_out;
        end
      end
      ONE: begin
        if (fifo_pop && !drn) begin
          state_d = TWO;
          slot1_d = fifo_out;
        end else if (fifo_pop && drn) begin
          slot0_d = fifo_out;
        end else if (drn) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // Pop is blocked here, so only a transfer can move the buffer.
        if (drn) begin
          state_d = ONE;
          slot0_d = slot1_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always @(posedge clk) begin
    if (!reset) begin
      a_pop_push:  assert (!(fifo_pop && fifo_push));
      a_pop_empty: assert (!(fifo_pop && fifo_empty));
      a_count:     assert (state_q != 2'd3);
      a_valid_x:   assert (!$isunknown(m_valid));
      a_data_x:    assert (!m_valid || !$isunknown(m_data));
    end
  end

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Directed bench for fifo_stream_drain: FIFO model feeding the DUT, scoreboard
// monitor on the stream side, and directed checks for each scenario.

module tb_fifo_stream_drain;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       fifo_empty;
  logic [7:0] fifo_out;
  logic       fifo_push;
  logic       fifo_pop;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [3:0] words_out;
  logic [1:0] dbg_state;

  logic [7:0] push_data;
  logic [7:0] mem [0:63];
  logic [5:0] wptr, rptr;

  logic [7:0] exp_q [$];
  logic [3:0] exp_words;
  int         total, bad, pop_cnt, p0;

  fifo_stream_drain #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .fifo_empty(fifo_empty), .fifo_out(fifo_out), .fifo_push(fifo_push),
    .fifo_pop(fifo_pop), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .words_out(words_out), .dbg_state(dbg_state)
  );

  // clock / FIFO model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_empty = (rptr == wptr);
  assign fifo_out   = mem[rptr];

  always @(posedge clk) begin
    if (reset) begin
      rptr <= '0;
      wptr <= '0;
    end else begin
      if (fifo_push) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + 6'd1;
      end
      if (fifo_pop) rptr <= rptr + 6'd1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: transfer occurs at the posedge after this negedge
  always @(negedge clk) begin
    if (reset) begin
      exp_words = '0;
    end else begin
      check("words_out_track", 32'(words_out), 32'(exp_words));
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_word: got %0h expected none", m_data);
        end else begin
          check("m_data_order", 32'(m_data), 32'(exp_q.pop_front()));
        end
        exp_words = exp_words + 4'd1;
      end
      if (fifo_pop) pop_cnt++;
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    enable    = 1'b0;
    fifo_push = 1'b0;
    m_ready   = 1'b0;
    exp_q.delete();
    step(2);
    reset = 1'b0;
  endtask

  task automatic load(input logic [7:0] w);
    push_data = w;
    fifo_push = 1'b1;
    exp_q.push_back(w);
    step(1);
    fifo_push = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; pop_cnt = 0;
    exp_words = '0;
    push_data = '0;
    reset = 1'b1; enable = 1'b0; fifo_push = 1'b0; m_ready = 1'b0;
    #1;
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_words_out", 32'(words_out), 0);
    check("rst_m_data", 32'(m_data), 0);
    check("rst_fifo_pop", 32'(fifo_pop), 0);
    do_reset();

    // T1 stream
    m_ready = 1'b1; enable = 1'b1;
    load(8'h11); load(8'h22); load(8'h33);
    @(negedge clk); check("t1_pop_c1", 32'(fifo_pop), 1);
    @(negedge clk); check("t1_pop_c2", 32'(fifo_pop), 1);
    check("t1_latency_valid", 32'(m_valid), 1);
    check("t1_latency_data", 32'(m_data), 'h11);
    @(negedge clk); check("t1_pop_c3", 32'(fifo_pop), 1);
    check("t1_data_c3", 32'(m_data), 'h22);
    @(negedge clk); check("t1_pop_c4", 32'(fifo_pop), 0);
    check("t1_data_c4", 32'(m_data), 'h33);
    step(3);
    check("t1_words_out", 32'(words_out), 3);

    // T2 backpressure
    do_reset();
    enable = 1'b1;
    p0 = pop_cnt;
    load(8'h11); load(8'h22); load(8'h33); load(8'h44);
    step(2);
    check("t2_hold_data_a", 32'(m_data), 'h11);
    step(2);
    check("t2_pops", 32'(pop_cnt - p0), 2);
    check("t2_valid", 32'(m_valid), 1);
    check("t2_hold_data_b", 32'(m_data), 'h11);
    check("t2_state_two", 32'(dbg_state), 2);
    m_ready = 1'b1;
    step(8);
    check("t2_pops_total", 32'(pop_cnt - p0), 4);
    check("t2_words_out", 32'(words_out), 4);
    check("t2_sb_empty", 32'(exp_q.size()), 0);
    check("t2_valid_end", 32'(m_valid), 0);

    // T3 push collision
    do_reset();
    m_ready = 1'b1;
    load(8'h51); load(8'h52);
    p0 = pop_cnt;
    enable = 1'b1;
    push_data = 8'h53; fifo_push = 1'b1; exp_q.push_back(8'h53);
    @(negedge clk); check("t3_no_pop_a", 32'(fifo_pop), 0);
    step(1);
    push_data = 8'h54; fifo_push = 1'b1; exp_q.push_back(8'h54);
    @(negedge clk); check("t3_no_pop_b", 32'(fifo_pop), 0);
    step(1);
    fifo_push = 1'b0;
    @(negedge clk); check("t3_pop_resumes", 32'(fifo_pop), 1);
    step(8);
    check("t3_pops", 32'(pop_cnt - p0), 4);
    check("t3_words_out", 32'(words_out), 4);
    check("t3_sb_empty", 32'(exp_q.size()), 0);

    // T4 enable
    do_reset();
    enable = 1'b1;
    load(8'h61); load(8'h62); load(8'h63);
    step(3);
    check("t4_state_two", 32'(dbg_state), 2);
    enable = 1'b0; m_ready = 1'b1;
    p0 = pop_cnt;
    step(4);
    check("t4_words_disabled", 32'(words_out), 2);
    check("t4_valid_drained", 32'(m_valid), 0);
    check("t4_no_pops", 32'(pop_cnt - p0), 0);
    enable = 1'b1;
    step(4);
    check("t4_words_resumed", 32'(words_out), 3);
    check("t4_pops_resumed", 32'(pop_cnt - p0), 1);
    check("t4_state_empty", 32'(dbg_state), 0);

    // T5 reset mid-stream
    do_reset();
    enable = 1'b1;
    load(8'h70); load(8'h71); load(8'h72); load(8'h73); load(8'h74);
    step(3);
    m_ready = 1'b1;
    step(1);
    m_ready = 1'b0;
    step(1);
    check("t5_words_before", 32'(words_out), 1);
    check("t5_state_two", 32'(dbg_state), 2);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("t5_async_valid", 32'(m_valid), 0);
    check("t5_async_words", 32'(words_out), 0);
    check("t5_async_pop", 32'(fifo_pop), 0);
    @(negedge clk); check("t5_pop_in_reset_a", 32'(fifo_pop), 0);
    @(negedge clk); check("t5_pop_in_reset_b", 32'(fifo_pop), 0);
    step(1);
    reset = 1'b0;
    enable = 1'b0;
    step(3);
    check("t5_valid_after", 32'(m_valid), 0);

    // T6 counter wrap (CNT_W=4)
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 17; i++) load(8'(8'h80 + i));
    step(3);
    for (int i = 1; i <= 17; i++) begin
      m_ready = 1'b1;
      step(1);
      m_ready = 1'b0;
      @(negedge clk);
      check("t6_words_wrap", 32'(words_out), 32'(i % 16));
      step(1);
    end
    check("t6_sb_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
